// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Detects load-use hazards,
//                squashes the front end on taken branches, holds the whole
//                pipeline during multi-cycle MUL/DIV operations with a
//                timeout watchdog, and keeps saturating stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ID_rs1,
   input  logic [4:0]  ID_rs2,
   input  logic        ID_use_rs1,
   input  logic        ID_use_rs2,
   input  logic        ID_EX_MemRead,
   input  logic [4:0]  ID_EX_rd,
   input  logic        EX_branch_taken,
   input  logic        EX_is_muldiv,
   input  logic        md_done,
   output logic        md_start,
   output logic        PC_stall,
   output logic        IF_ID_stall,
   output logic        ID_EX_stall,
   output logic        IF_ID_flush,
   output logic        ID_EX_flush,
   output logic        EX_MEM_flush,
   output logic        md_err,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam logic [5:0]  c_WAIT_LIMIT = 6'd63;
   localparam logic [15:0] c_CNT_MAX    = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MD_WAIT = 2'd1,
      ERR     = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [5:0]  r_wait_cnt;
   logic        r_md_err;
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   logic        w_lu;
   logic        w_md_go;
   logic        w_md_hold;
   logic        w_md_start;
   logic        w_pc_stall;
   logic        w_if_id_stall;
   logic        w_id_ex_stall;
   logic        w_if_id_flush;
   logic        w_id_ex_flush;
   logic        w_ex_mem_flush;

   // A load in EX feeds an operand that ID really reads; x0 never conflicts.
   assign w_lu = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                 ((ID_use_rs1 && (ID_EX_rd == ID_rs1)) ||
                  (ID_use_rs2 && (ID_EX_rd == ID_rs2)));

   assign w_md_go   = (r_state == IDLE) && EX_is_muldiv;
   assign w_md_hold = w_md_go || ((r_state == MD_WAIT) && !md_done);

   // Next-state and control decode; muldiv outranks branch, branch outranks load-use.
   always_comb begin
      w_state_nxt    = r_state;
      w_md_start     = 1'b0;
      w_pc_stall     = 1'b0;
      w_if_id_stall  = 1'b0;
      w_id_ex_stall  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_flush = 1'b0;

      if (w_md_hold) begin
         w_pc_stall     = 1'b1;
         w_if_id_stall  = 1'b1;
         w_id_ex_stall  = 1'b1;
         w_ex_mem_flush = 1'b1;
      end

      case (r_state)
         IDLE: begin
            if (w_md_go) begin
               w_md_start  = 1'b1;
               w_state_nxt = MD_WAIT;
            end else if (EX_branch_taken) begin
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (w_lu) begin
               w_pc_stall    = 1'b1;
               w_if_id_stall = 1'b1;
               w_id_ex_flush = 1'b1;
            end
         end
         MD_WAIT: begin
            if (md_done) begin
               w_state_nxt = IDLE;
            end else if (r_wait_cnt == c_WAIT_LIMIT) begin
               w_state_nxt = ERR;
            end
         end
         ERR: begin
            // Watchdog tripped: stay quiet until reset.
            w_state_nxt = ERR;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Wait counter: zeroed when the operation is launched, counts MD_WAIT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= 6'd0;
      end else if (w_md_go) begin
         r_wait_cnt <= 6'd0;
      end else if (r_state == MD_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 6'd1;
      end
   end

   // Sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_md_err <= 1'b0;
      end else if ((r_state == MD_WAIT) && (w_state_nxt == ERR)) begin
         r_md_err <= 1'b1;
      end
   end

   // Saturating performance counters for PC stalls and front-end flushes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= 16'd0;
         r_flush_cnt <= 16'd0;
      end else begin
         if (w_pc_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (w_if_id_flush && (r_flush_cnt != c_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end

   // Outputs are gated by rst_n so they drop immediately, independent of clk.
   assign md_start     = rst_n & w_md_start;
   assign PC_stall     = rst_n & w_pc_stall;
   assign IF_ID_stall  = rst_n & w_if_id_stall;
   assign ID_EX_stall  = rst_n & w_id_ex_stall;
   assign IF_ID_flush  = rst_n & w_if_id_flush;
   assign ID_EX_flush  = rst_n & w_id_ex_flush;
   assign EX_MEM_flush = rst_n & w_ex_mem_flush;
   assign md_err       = r_md_err;
   assign stall_cnt    = r_stall_cnt;
   assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic [4:0]  ID_rs1, ID_rs2;
   logic        ID_use_rs1, ID_use_rs2;
   logic        ID_EX_MemRead;
   logic [4:0]  ID_EX_rd;
   logic        EX_branch_taken, EX_is_muldiv, md_done;
   logic        md_start, PC_stall, IF_ID_stall, ID_EX_stall;
   logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush, md_err;
   logic [15:0] stall_cnt, flush_cnt;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
      .EX_branch_taken(EX_branch_taken), .EX_is_muldiv(EX_is_muldiv),
      .md_done(md_done), .md_start(md_start),
      .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
      .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
      .md_err(md_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {md_start, PC_stall, IF_ID_stall, ID_EX_stall, IF_ID_flush, ID_EX_flush, EX_MEM_flush, md_err}
   logic [7:0] obs;
   assign obs = {md_start, PC_stall, IF_ID_stall, ID_EX_stall,
                 IF_ID_flush, ID_EX_flush, EX_MEM_flush, md_err};

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   bit m_busy;
   bit m_err;
   int m_wait;
   int m_stall;
   int m_flush;

   function automatic bit m_lu();
      return ID_EX_MemRead && (ID_EX_rd != 0) &&
             ((ID_use_rs1 && ID_EX_rd == ID_rs1) || (ID_use_rs2 && ID_EX_rd == ID_rs2));
   endfunction

   function automatic logic [7:0] m_expect();
      if (!rst_n)        return 8'b0000_0000;
      if (m_err)         return 8'b0000_0001;
      if (m_busy)        return md_done ? 8'b0000_0000 : 8'b0111_0010;
      if (EX_is_muldiv)  return 8'b1111_0010;
      if (EX_branch_taken) return 8'b0000_1100;
      if (m_lu())        return 8'b0110_0100;
      return 8'b0000_0000;
   endfunction

   task automatic m_reset();
      m_busy = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
   endtask

   // Advance the model over the upcoming rising edge, then go to the next falling edge.
   task automatic tick();
      logic [7:0] e;
      e = m_expect();
      if (e[6]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (e[3]) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      if (!m_err) begin
         if (!m_busy) begin
            if (EX_is_muldiv) begin m_busy = 1; m_wait = 0; end
         end else if (md_done) begin
            m_busy = 0;
         end else begin
            m_wait++;
            if (m_wait == 64) begin m_busy = 0; m_err = 1; end
         end
      end
      @(negedge clk);
   endtask

   task automatic clr_inputs();
      ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
      ID_EX_MemRead = 0; ID_EX_rd = 0;
      EX_branch_taken = 0; EX_is_muldiv = 0; md_done = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst_n = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
      ID_EX_MemRead = 1; ID_EX_rd = rd; ID_rs1 = rs1; ID_use_rs1 = use1;
      ID_rs2 = 5'd31; ID_use_rs2 = 0;
   endtask

   task automatic test_reset();
      clr_inputs();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      EX_is_muldiv = 1; set_lu(5'd5, 5'd5, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 8'h00); end
      n_checks++;
      if ({stall_cnt, flush_cnt} !== 32'h0) begin
         n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", stall_cnt, flush_cnt);
      end
      do_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      set_lu(5'd5, 5'd5, 1'b1);
      #1;
      n_checks++;
      if (obs !== 8'b0110_0100) begin n_fail++; $display("FAIL load_use_outputs: got %b want %b", obs, 8'b0110_0100); end
      tick();
      clr_inputs();
      #1;
      n_checks++;
      if (obs !== 8'h00) begin n_fail++; $display("FAIL load_use_one_bubble: got %b want 0", obs); end
      n_checks++;
      if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt); end
      tick();
      set_lu(5'd0, 5'd0, 1'b1);
      #1;
      n_checks++;
      if (obs !== 8'h00) begin n_fail++; $display("FAIL lu_x0: got %b want 0", obs); end
      tick();
      set_lu(5'd5, 5'd5, 1'b0);
      #1;
      n_checks++;
      if (obs !== 8'h00) begin n_fail++; $display("FAIL lu_unused_rs1: got %b want 0", obs); end
      tick();
      clr_inputs();
      ID_EX_MemRead = 1; ID_EX_rd = 5'd9; ID_rs2 = 5'd9; ID_use_rs2 = 1; ID_rs1 = 5'd3; ID_use_rs1 = 1;
      #1;
      n_checks++;
      if (obs !== 8'b0110_0100) begin n_fail++; $display("FAIL lu_rs2: got %b want %b", obs, 8'b0110_0100); end
      tick();
      clr_inputs();
   endtask

   task automatic test_branch();
      int f0;
      do_reset();
      f0 = flush_cnt;
      set_lu(5'd5, 5'd5, 1'b1);
      EX_branch_taken = 1;
      #1;
      n_checks++;
      if (obs !== 8'b0000_1100) begin n_fail++; $display("FAIL branch_over_lu: got %b want %b", obs, 8'b0000_1100); end
      tick();
      clr_inputs();
      #1;
      n_checks++;
      if (flush_cnt !== 16'(f0 + 1)) begin n_fail++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_cnt, f0 + 1); end
      tick();
   endtask

   task automatic test_muldiv();
      int starts, stalls;
      do_reset();
      starts = 0; stalls = 0;
      EX_is_muldiv = 1;
      EX_branch_taken = 1;   // illegal combo: muldiv must win
      for (int c = 0; c < 7; c++) begin
         md_done = (c == 4);
         if (c >= 5) begin EX_is_muldiv = 0; EX_branch_taken = 0; end
         #1;
         n_checks++;
         if (obs !== m_expect()) begin n_fail++; $display("FAIL muldiv_cycle%0d: got %b want %b", c, obs, m_expect()); end
         starts += md_start;
         stalls += PC_stall;
         tick();
      end
      n_checks++;
      if (starts != 1) begin n_fail++; $display("FAIL muldiv_start_pulses: got %0d want 1", starts); end
      n_checks++;
      if (stalls != 4) begin n_fail++; $display("FAIL muldiv_stall_cycles: got %0d want 4", stalls); end
      n_checks++;
      if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL muldiv_stall_cnt: got %0d want 4", stall_cnt); end
      clr_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
         ID_EX_rd = 5'($urandom_range(0, 3));
         ID_use_rs1 = 1'($urandom); ID_use_rs2 = 1'($urandom);
         ID_EX_MemRead = 1'($urandom);
         EX_branch_taken = ($urandom_range(0, 3) == 0);
         EX_is_muldiv = ($urandom_range(0, 7) == 0);
         md_done = ($urandom_range(0, 2) == 0);
         #1;
         n_checks++;
         if (obs !== m_expect()) begin n_fail++; $display("FAIL random_outputs c%0d: got %b want %b", c, obs, m_expect()); end
         n_checks++;
         if ({stall_cnt, flush_cnt} !== {16'(m_stall), 16'(m_flush)}) begin
            n_fail++; $display("FAIL random_counters c%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt, m_stall, m_flush);
         end
         tick();
      end
      clr_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      EX_is_muldiv = 1;
      for (int c = 0; c < 70; c++) begin
         if (c == 66) set_lu(5'd5, 5'd5, 1'b1);  // ERR ignores hazards
         if (c == 67) md_done = 1;                // and md_done
         #1;
         n_checks++;
         if (obs !== m_expect()) begin n_fail++; $display("FAIL timeout_cycle%0d: got %b want %b", c, obs, m_expect()); end
         if (c == 65) begin
            n_checks++;
            if ({md_err, PC_stall, md_start} !== 3'b100) begin
               n_fail++; $display("FAIL timeout_err_set: got err/stall/start %b want 100", {md_err, PC_stall, md_start});
            end
         end
         tick();
      end
      n_checks++;
      if (stall_cnt !== 16'd65) begin n_fail++; $display("FAIL timeout_stall_cnt: got %0d want 65", stall_cnt); end
      do_reset();
      #1;
      n_checks++;
      if (md_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_cleared: got %b want 0", md_err); end
      tick();
   endtask

   task automatic test_saturation();
      do_reset();
      set_lu(5'd7, 5'd7, 1'b1);
      for (int c = 0; c < 65536; c++) tick();
      #1;
      n_checks++;
      if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want FFFF", stall_cnt); end
      tick();
      #1;
      n_checks++;
      if (stall_cnt !== 16'hFFFF || PC_stall !== 1'b1) begin
         n_fail++; $display("FAIL sat_hold: got %h stall %b want FFFF 1", stall_cnt, PC_stall);
      end
      tick();
      clr_inputs();
   endtask

   task automatic test_async_reset();
      EX_is_muldiv = 1;
      tick();
      tick();
      #1;
      n_checks++;
      if (obs !== 8'b0111_0010) begin n_fail++; $display("FAIL async_pre_wait: got %b want %b", obs, 8'b0111_0010); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== 8'h00) begin n_fail++; $display("FAIL async_outputs: got %b want 0", obs); end
      n_checks++;
      if ({stall_cnt, flush_cnt} !== 32'h0) begin
         n_fail++; $display("FAIL async_counters: got %h/%h want 0/0", stall_cnt, flush_cnt);
      end
      m_reset();
      EX_is_muldiv = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++;
         if (obs !== 8'h00) begin n_fail++; $display("FAIL async_resume c%0d: got %b want 0", c, obs); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_muldiv();
      test_random();
      test_timeout();
      test_saturation();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
